gic_arbiter: RTL and testbench
==============================

GIC_ARBITER -- requirements
Module: gic_arbiter

Interface
REQ-001 SHALL have parameter nmasters, default 3, number of Wishbone requesters (legal range 2..4).
REQ-002 SHALL have parameter timeout, default 1024, cycles a granted strobe may wait for ack/err/rty before abort (legal range 4..65535).
REQ-003 SHALL have port wb_clk_i  input  1  single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports m_adr_i / m_dat_i  input  nmasters*32 each  per-master address/write data, master k at bits [32k+31:32k].
REQ-006 SHALL have port m_sel_i  input  nmasters*4  per-master byte selects.
REQ-007 SHALL have ports m_we_i, m_cyc_i, m_stb_i  input  nmasters each  per-master write enable, cycle, strobe.
REQ-008 SHALL have ports m_ack_o, m_err_o, m_rty_o  output  nmasters each  per-master termination.
REQ-009 SHALL have port m_dat_o  output  32  read data broadcast to all masters.
REQ-010 SHALL have ports s_adr_o, s_dat_o  output  32 each; s_sel_o  output  4; s_we_o, s_cyc_o, s_stb_o  output  1 each  to the GIC master slave port.
REQ-011 SHALL have ports s_ack_i, s_err_i, s_rty_i  input  1 each; s_dat_i  input  32  from the GIC master.
REQ-012 SHALL have port grant_o  output  nmasters  one-hot current owner; all-zero when idle.
REQ-013 SHALL have port timeout_o  output  1  single-cycle pulse on every watchdog abort.

Function
REQ-014 SHALL implement FSM states IDLE, BUS, RELEASE.
REQ-015 IDLE: when any m_cyc_i is high, register a one-hot grant and enter BUS on the next edge; otherwise stay.
REQ-016 Arbitration SHALL be round-robin: search starts at the master after the last granted index, wrapping from nmasters-1 to 0; after reset the last granted index is nmasters-1, so master 0 has first priority.
REQ-017 BUS: s_* outputs SHALL equal the granted master's inputs combinationally; non-granted masters SHALL see ack/err/rty low.
REQ-018 m_ack_o/m_err_o/m_rty_o of the granted master SHALL equal s_ack_i/s_err_i/s_rty_i combinationally in BUS, zero latency; m_dat_o = s_dat_i at all times.
REQ-019 Grant SHALL persist across multiple strobes while the granted m_cyc_i stays high; BUS -> RELEASE when the granted m_cyc_i falls.
REQ-020 RELEASE SHALL last exactly one cycle with s_cyc_o/s_stb_o low, then go to IDLE; arbitration gap is 2 cycles minimum.
REQ-021 Watchdog: a 16-bit counter SHALL clear on entering BUS and on every s_ack_i/s_err_i/s_rty_i, and increment each BUS cycle with s_stb_o high and no termination.
REQ-022 When the counter reaches timeout-1: m_err_o of the owner SHALL pulse for one cycle, timeout_o pulse, s_cyc_o/s_stb_o forced low that cycle, FSM enters RELEASE.
REQ-023 A termination arriving in the same cycle as the timeout SHALL win: it is forwarded, no err, no abort.
REQ-024 Requests raised in RELEASE SHALL be considered only in the following IDLE cycle; a master deasserting m_cyc_i before grant SHALL simply lose its request.

Reset
REQ-025 On wb_rst_i assertion, asynchronously: state=IDLE, grant_o=0, last index=nmasters-1, watchdog=0, timeout_o=0; all s_cyc_o/s_stb_o and m_ack/err/rty outputs low.
REQ-026 Reset mid-BUS SHALL abandon the transaction with no err pulse; first post-reset grant follows REQ-015 from IDLE.

Structure
REQ-027 State encodings and the default timeout SHALL live in shared package gic_pkg, alongside GIC line constants (initiate codes, idle).
REQ-028 Round-robin priority selection SHALL be sub-module gic_rr_pick (request vector + last index in, one-hot grant + index out, purely combinational).

Verification
REQ-029 Single request: m_cyc/stb[1]=1, read 0x0000_0010, s_ack_i after 3 cycles with s_dat_i=0xDEADBEEF -> grant_o=010 one cycle after request; m_ack_o[1] same cycle as s_ack_i; m_dat_o=0xDEADBEEF.
REQ-030 Fairness: all three masters request continuously, each ends cycle after one ack -> grant order 0,1,2,0,1,2 with 2-cycle gaps.
REQ-031 Timeout: timeout=8, master 2 strobes, slave never acks -> m_err_o[2] and timeout_o pulse on 8th BUS cycle; s_cyc_o low; master 0 grantable after RELEASE.
REQ-032 Race: s_ack_i arrives on the timeout-1 cycle -> m_ack_o asserted, m_err_o and timeout_o stay low.
REQ-033 Burst hold: master 0 holds cyc for 4 strobes while master 1 requests -> grant stays 001 for all 4 acks, then 010.
REQ-034 Async reset mid-BUS -> outputs low immediately without clock edge; no m_err_o; subsequent request from master 0 granted first.

Source files
------------

// File: rtl/gic_pkg.sv
// Shared definitions for the GIC-side Wishbone arbiter: FSM encodings,
// watchdog sizing and GIC line codes.
package gic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_RELEASE = 2'd2
  } gic_state_e;

  localparam int GIC_TIMEOUT_DEFAULT = 1024;
  localparam int GIC_WD_WIDTH        = 16;

  // Encodings driven on the GIC initiate lines.
  localparam logic [1:0] GIC_LINE_IDLE  = 2'b00;
  localparam logic [1:0] GIC_INIT_READ  = 2'b01;
  localparam logic [1:0] GIC_INIT_WRITE = 2'b10;
  localparam logic [1:0] GIC_INIT_ABORT = 2'b11;

endpackage

// File: rtl/gic_rr_pick.sv
// Combinational round-robin picker: the search starts one past the last
// granted index and wraps, returning a one-hot grant plus its index.
module gic_rr_pick #(
  parameter  int n  = 3,
  localparam int iw = $clog2(n)
) (
  input  logic [n-1:0]  req,
  input  logic [iw-1:0] last,
  output logic [n-1:0]  grant,
  output logic [iw-1:0] idx,
  output logic          valid
);

  always_comb begin
    int cand;
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path can leave a value held (no latch).
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int off = 1; off <= n; off++) begin
      cand = (int'(last) + off) % n;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = iw'(cand);
      end
    end
  end

endmodule

// File: rtl/gic_arbiter.sv
// Round-robin arbiter of several Wishbone masters onto the single GIC
// master slave port, with a per-transfer watchdog that aborts hung strobes.
module gic_arbiter
  import gic_pkg::*;
#(
  parameter int nmasters = 3,
  parameter int timeout  = GIC_TIMEOUT_DEFAULT
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [nmasters*32-1:0] m_adr_i,
  input  logic [nmasters*32-1:0] m_dat_i,
  input  logic [nmasters*4-1:0]  m_sel_i,
  input  logic [nmasters-1:0]    m_we_i,
  input  logic [nmasters-1:0]    m_cyc_i,
  input  logic [nmasters-1:0]    m_stb_i,
  output logic [nmasters-1:0]    m_ack_o,
  output logic [nmasters-1:0]    m_err_o,
  output logic [nmasters-1:0]    m_rty_o,
  output logic [31:0]            m_dat_o,
  output logic [31:0]            s_adr_o,
  output logic [31:0]            s_dat_o,
  output logic [3:0]             s_sel_o,
  output logic                   s_we_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  input  logic                   s_rty_i,
  input  logic [31:0]            s_dat_i,
  output logic [nmasters-1:0]    grant_o,
  output logic                   timeout_o
);

  localparam int iw = $clog2(nmasters);

  gic_state_e              state, state_next;
  logic [nmasters-1:0]     grant_q;
  logic [iw-1:0]           last_q;
  logic [GIC_WD_WIDTH-1:0] wd_q;

  logic [nmasters-1:0] pick_grant;
  logic [iw-1:0]       pick_idx;
  logic                pick_valid;

  logic in_bus, owner_cyc, owner_stb, term, abort;

  gic_rr_pick #(.n(nmasters)) u_pick (
    .req   (m_cyc_i),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign in_bus    = (state == ST_BUS);
  assign owner_cyc = |(grant_q & m_cyc_i);
  assign owner_stb = |(grant_q & m_stb_i);
  assign term      = s_ack_i | s_err_i | s_rty_i;
  // A slave termination in the watchdog's last cycle wins over the abort.
  assign abort     = in_bus && owner_stb && !term &&
                     (wd_q == GIC_WD_WIDTH'(timeout - 1));

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    for (int k = 0; k < nmasters; k++) begin
      if (grant_q[k]) begin
        s_adr_o = m_adr_i[32*k +: 32];
        s_dat_o = m_dat_i[32*k +: 32];
        s_sel_o = m_sel_i[4*k +: 4];
        s_we_o  = m_we_i[k];
      end
    end
  end

  assign s_cyc_o   = in_bus && owner_cyc && !abort;
  assign s_stb_o   = in_bus && owner_stb && !abort;
  assign m_ack_o   = in_bus ? (grant_q & {nmasters{s_ack_i}}) : '0;
  assign m_err_o   = in_bus ? (grant_q & {nmasters{s_err_i | abort}}) : '0;
  assign m_rty_o   = in_bus ? (grant_q & {nmasters{s_rty_i}}) : '0;
  assign m_dat_o   = s_dat_i;
  assign grant_o   = grant_q;
  assign timeout_o = abort;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (pick_valid) state_next = ST_BUS;
      ST_BUS:     if (abort || !owner_cyc) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values; reset is asynchronous, so comb outputs gated by state
  // drop the moment wb_rst_i rises.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      last_q  <= iw'(nmasters - 1);
      wd_q    <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_grant;
            last_q  <= pick_idx;
            wd_q    <= '0;
          end
        end
        ST_BUS: begin
          if (state_next != ST_BUS) grant_q <= '0;
          if (term)           wd_q <= '0;
          else if (owner_stb) wd_q <= wd_q + 1'b1;
        end
        default: grant_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gic_arbiter.sv
// Directed bench for gic_arbiter: single transfer, round-robin fairness,
// watchdog abort, ack/timeout race, burst hold and async reset.
module tb_gic_arbiter;

  localparam int NM = 3;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [95:0]   m_adr, m_dat;
  logic [11:0]   m_sel;
  logic [2:0]    m_we, m_cyc, m_stb;
  logic [2:0]    m_ack, m_err, m_rty;
  logic [31:0]   m_dat_o;
  logic [31:0]   s_adr, s_dat_o, s_dat_i;
  logic [3:0]    s_sel;
  logic          s_we, s_cyc, s_stb;
  logic          s_ack, s_err, s_rty;
  logic [2:0]    grant;
  logic          tmo;

  int n_checks = 0;
  int n_fail   = 0;

  gic_arbiter #(.nmasters(NM), .timeout(TO)) dut (
    .wb_clk_i (clk),     .wb_rst_i (rst),
    .m_adr_i  (m_adr),   .m_dat_i  (m_dat),   .m_sel_i (m_sel),
    .m_we_i   (m_we),    .m_cyc_i  (m_cyc),   .m_stb_i (m_stb),
    .m_ack_o  (m_ack),   .m_err_o  (m_err),   .m_rty_o (m_rty),
    .m_dat_o  (m_dat_o),
    .s_adr_o  (s_adr),   .s_dat_o  (s_dat_o), .s_sel_o (s_sel),
    .s_we_o   (s_we),    .s_cyc_o  (s_cyc),   .s_stb_o (s_stb),
    .s_ack_i  (s_ack),   .s_err_i  (s_err),   .s_rty_i (s_rty),
    .s_dat_i  (s_dat_i),
    .grant_o  (grant),   .timeout_o (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [31:0] adr, input logic we);
    m_adr[32*k +: 32] = adr;
    m_dat[32*k +: 32] = adr ^ 32'h5A5A_0000;
    m_sel[4*k +: 4]   = 4'hF;
    m_we[k]  = we;
    m_cyc[k] = 1'b1;
    m_stb[k] = 1'b1;
  endtask

  task automatic drop(input int k);
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
  endtask

  task automatic reset_dut;
    rst = 1'b1;
    m_adr = '0; m_dat = '0; m_sel = '0;
    m_we = '0; m_cyc = '0; m_stb = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_i = '0;
    step;
    step;
    rst = 1'b0;
  endtask

  initial begin
    reset_dut;
    rst = 1'b1;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_s_cyc", 32'(s_cyc), 32'h0);
    check("rst_tmo",   32'(tmo),   32'h0);
    check("rst_m_err", 32'(m_err), 32'h0);
    step;
    rst = 1'b0;

    // Single read from master 1, slave acks on the 4th BUS cycle.
    set_req(1, 32'h0000_0010, 1'b0);
    #1;
    check("single_idle_grant", 32'(grant), 32'h0);
    step;
    #1;
    check("single_grant", 32'(grant), 32'h2);
    check("single_s_cyc", 32'(s_cyc), 32'h1);
    check("single_s_adr", s_adr, 32'h0000_0010);
    step;
    step;
    step;
    s_ack = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    check("single_m_ack", 32'(m_ack), 32'h2);
    check("single_m_dat", m_dat_o, 32'hDEAD_BEEF);
    check("single_no_tmo", 32'(tmo), 32'h0);
    step;
    s_ack = 1'b0;
    drop(1);
    #1;
    check("single_cyc_fall", 32'(s_cyc), 32'h0);
    step;
    #1;
    check("single_release_grant", 32'(grant), 32'h0);

    // Fairness: all three request continuously, one ack each.
    reset_dut;
    for (int k = 0; k < NM; k++) set_req(k, 32'h100 * (k + 1), k == 2);
    for (int r = 0; r < 6; r++) begin
      int g;
      g = r % 3;
      step;
      #1;
      check($sformatf("rr_grant_%0d", r), 32'(grant), 32'(1 << g));
      check($sformatf("rr_adr_%0d", r), s_adr, 32'h100 * (g + 1));
      s_ack = 1'b1;
      #1;
      check($sformatf("rr_ack_%0d", r), 32'(m_ack), 32'(1 << g));
      step;
      s_ack = 1'b0;
      drop(g);
      step;
      #1;
      check($sformatf("rr_gap1_%0d", r), 32'(grant | 3'(s_cyc)), 32'h0);
      set_req(g, 32'h100 * (g + 1), g == 2);
      step;
      #1;
      check($sformatf("rr_gap2_%0d", r), 32'(grant), 32'h0);
    end

    // Watchdog abort: master 2 strobes, slave never answers.
    reset_dut;
    set_req(2, 32'h0000_0200, 1'b1);
    step;
    for (int c = 1; c < TO; c++) begin
      #1;
      check($sformatf("wd_wait_%0d", c), 32'({tmo, m_err, s_cyc}), 32'h1);
      step;
    end
    set_req(0, 32'h0000_0300, 1'b0);
    #1;
    check("wd_err",   32'(m_err), 32'h4);
    check("wd_tmo",   32'(tmo),   32'h1);
    check("wd_s_cyc", 32'({s_cyc, s_stb}), 32'h0);
    step;
    drop(2);
    #1;
    check("wd_release", 32'({grant, tmo, m_err}), 32'h0);
    step;
    step;
    #1;
    check("wd_next_grant", 32'(grant), 32'h1);
    drop(0);

    // Race: ack lands on the watchdog's last cycle.
    reset_dut;
    set_req(1, 32'h0000_0400, 1'b0);
    step;
    for (int c = 1; c < TO; c++) step;
    s_ack = 1'b1;
    #1;
    check("race_ack",   32'(m_ack), 32'h2);
    check("race_err",   32'(m_err), 32'h0);
    check("race_tmo",   32'(tmo),   32'h0);
    check("race_s_cyc", 32'(s_cyc), 32'h1);
    step;
    s_ack = 1'b0;
    #1;
    check("race_hold", 32'({grant, tmo}), 32'(3'b010 << 1));

    // Burst hold: master 0 keeps cyc for 4 acks while master 1 waits.
    reset_dut;
    set_req(0, 32'h0000_0500, 1'b1);
    set_req(1, 32'h0000_0600, 1'b0);
    step;
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b1;
      #1;
      check($sformatf("burst_ack_%0d", b), 32'({grant, m_ack}), 32'h09);
      step;
      s_ack = 1'b0;
      step;
    end
    drop(0);
    #1;
    check("burst_cyc_fall", 32'(s_cyc), 32'h0);
    step;
    step;
    step;
    #1;
    check("burst_next_grant", 32'(grant), 32'h2);
    check("burst_next_adr", s_adr, 32'h0000_0600);

    // Async reset in the middle of master 1's transfer.
    check("areset_pre_cyc", 32'(s_cyc), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("areset_grant", 32'(grant), 32'h0);
    check("areset_s_bus", 32'({s_cyc, s_stb}), 32'h0);
    check("areset_m_err", 32'({m_err, tmo}), 32'h0);
    step;
    rst = 1'b0;
    set_req(0, 32'h0000_0700, 1'b0);
    #1;
    check("areset_idle", 32'(grant), 32'h0);
    step;
    #1;
    check("areset_first_grant", 32'(grant), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
